mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port-to-one memory arbiter sitting between the LC-3b pipeline and physical memory. It is the responder for the pipeline's fetch port (mem1, read-only) and data port (mem2, read/write with byte mask). It serializes both ports onto a single initiator port toward physical memory. Arbitration is fixed-priority with a starvation bound; every request is latched at grant and answered with a one-cycle response pulse.

## Interface
- STARVE_LIMIT, 4: consecutive data-port grants tolerated while fetch is pending; 0 disables the bound (data always wins ties).
- clk  in  1  system clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high reset
- mem1_read  in  1  fetch-port read request, held until mem1_resp
- mem1_address  in  16  fetch address (lc3b_word)
- mem1_rdata  out  16  fetch read data, valid while mem1_resp=1
- mem1_resp  out  1  fetch completion pulse
- mem2_read  in  1  data-port read request
- mem2_write  in  1  data-port write request
- mem2_wmask  in  2  byte write mask (lc3b_mem_wmask)
- mem2_address  in  16  data address
- mem2_wdata  in  16  write data
- mem2_rdata  out  16  data read data, valid while mem2_resp=1
- mem2_resp  out  1  data completion pulse
- pmem_read, pmem_write  out  1 each  physical-memory request strobes
- pmem_wmask  out  2  physical write mask
- pmem_address  out  16  physical address
- pmem_wdata  out  16  physical write data
- pmem_rdata  in  16  physical read data, valid with pmem_resp
- pmem_resp  in  1  physical completion, single cycle

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE arbitration, evaluated each cycle:
  - Data pending (mem2_read|mem2_write) and fetch not pending: grant D.
  - Fetch only: grant I.
  - Both pending: grant I if STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT, else grant D.
- Grant latches address, wdata, wmask and op into request registers; next state I_BUSY/D_BUSY.
- mem2_read and mem2_write both high: treated as a write.
- I_BUSY/D_BUSY:
  - pmem_* driven from the latched request; pmem_read or pmem_write held high until pmem_resp.
  - On pmem_resp: capture pmem_rdata into the granted port's rdata register, go to DONE.
- DONE lasts exactly one cycle.
  - Granted port's resp=1 and its rdata holds the captured value.
  - pmem strobes are 0.
  - Next state IDLE.
  - The DONE bubble lets the requester drop its request before IDLE re-samples.
- starve_cnt:
  - Width $clog2(STARVE_LIMIT+1).
  - Cleared on an I grant.
  - Incremented (saturating) on a D grant while mem1_read=1.
  - Unchanged otherwise.
- Requester deasserting mid-transaction: the transaction completes from latched values and the resp pulse still fires.
- Write responses: mem2_rdata = pmem_rdata captured; the pipeline ignores it.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all strobes and resp 0; rdata, address, wdata, wmask 0; starve_cnt 0.
- Request seen in IDLE at cycle 0:
  - pmem strobe high at cycle 1.
  - pmem_resp at cycle k≥1 gives port resp at cycle k+1, then IDLE at k+2.
  - Minimum request-to-resp latency is 2 cycles; issue interval is ≥3 cycles per transaction.
- pmem_resp outside I_BUSY/D_BUSY is ignored.
- Reset mid-transaction: all outputs take reset values at the next edge and no resp fires. Physical memory must tolerate an abandoned strobe.
- The arbiter never drives pmem_read and pmem_write in the same cycle, and never asserts both resp outputs in the same cycle.

## Structure
- lc3b_types gains typedef enum lc3b_arb_state {arb_idle, arb_i_busy, arb_d_busy, arb_done}.
- Existing lc3b_word and lc3b_mem_wmask are reused for the ports.
- One sub-module, arb_req_latch: holds address, wdata, wmask, write flag and granted-port flag, loaded on grant. The FSM and starve_cnt stay in mem_arbiter.

## Test plan
- Fetch only: mem1_read, addr 0x3000; pmem_resp with 0x1234 two cycles after pmem_read -> mem1_resp one cycle, mem1_rdata=0x1234; pmem_address=0x3000 throughout.
- Simultaneous: mem1_read at 0x0010, mem2_write 0x00AB at 0x0020, wmask 2'b01 -> D served first (pmem_write, wmask 01), then I; exactly one resp per port.
- Starvation, STARVE_LIMIT=2: mem1 held, mem2 re-requesting continuously -> grants D, D, I; starve_cnt returns to 0.
- Requester drops mem2_read the cycle after grant -> pmem_read stays high until pmem_resp, mem2_resp still pulses once, address unchanged.
- Reset asserted during D_BUSY -> next cycle pmem strobes 0, no mem2_resp, state IDLE; a subsequent fetch completes normally.
- mem2_read and mem2_write both high -> pmem_write issued, pmem_read never asserted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared LC-3b memory types plus the arbiter state encoding.
//   lc3b_word       - 16-bit address/data word
//   lc3b_mem_wmask  - 2-bit byte write mask
//   lc3b_arb_state  - arbiter FSM states
//   starve_cnt_width - width of the starvation counter for a given limit
package mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    arb_idle   = 2'd0,
    arb_i_busy = 2'd1,
    arb_d_busy = 2'd2,
    arb_done   = 2'd3
  } lc3b_arb_state;

  localparam lc3b_word      WORD_ZERO  = 16'h0000;
  localparam lc3b_mem_wmask WMASK_NONE = 2'b00;

  // A limit of 0 disables the bound, but the counter still needs one bit so
  // the declaration stays legal.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    if (limit == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(limit + 32'd1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_req_latch.sv
// arb_req_latch: request registers loaded when the arbiter grants a port.
// The contents drive the physical-memory port for the whole transaction, so
// a requester may change or drop its inputs after grant without effect.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (clears all)
//   load              - grant strobe; captures the load_* inputs
//   load_port_d       - 1 = data port granted, 0 = fetch port granted
//   load_write        - 1 = write transaction
//   load_address/wdata/wmask - request payload to capture
//   port_d, write, address, wdata, wmask - latched request
module arb_req_latch
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          load_port_d,
  input  logic          load_write,
  input  lc3b_word      load_address,
  input  lc3b_word      load_wdata,
  input  lc3b_mem_wmask load_wmask,
  output logic          port_d,
  output logic          write,
  output lc3b_word      address,
  output lc3b_word      wdata,
  output lc3b_mem_wmask wmask
);

  logic          port_d_r;
  logic          write_r;
  lc3b_word      address_r;
  lc3b_word      wdata_r;
  lc3b_mem_wmask wmask_r;

  // Capture the granted request; hold it until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_d_r  <= 1'b0;
      write_r   <= 1'b0;
      address_r <= WORD_ZERO;
      wdata_r   <= WORD_ZERO;
      wmask_r   <= WMASK_NONE;
    end else if (load) begin
      port_d_r  <= load_port_d;
      write_r   <= load_write;
      address_r <= load_address;
      wdata_r   <= load_wdata;
      wmask_r   <= load_wmask;
    end else begin
      port_d_r  <= port_d_r;
      write_r   <= write_r;
      address_r <= address_r;
      wdata_r   <= wdata_r;
      wmask_r   <= wmask_r;
    end
  end

  assign port_d  = port_d_r;
  assign write   = write_r;
  assign address = address_r;
  assign wdata   = wdata_r;
  assign wmask   = wmask_r;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes the LC-3b fetch port (mem1, read-only) and data
// port (mem2, read/write) onto one physical-memory initiator port.
// Fixed priority to data, with fetch forced through after STARVE_LIMIT
// consecutive data grants while fetch waits (STARVE_LIMIT=0: data always
// wins). Each transaction: grant -> busy (strobe held until pmem_resp) ->
// one-cycle DONE with the port's resp pulse -> idle.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   mem1_read, mem1_address       - fetch request (held until mem1_resp)
//   mem1_rdata, mem1_resp         - fetch data and completion pulse
//   mem2_read/write/wmask/address/wdata - data request
//   mem2_rdata, mem2_resp         - data read data and completion pulse
//   pmem_read/write/wmask/address/wdata - physical request (registered)
//   pmem_rdata, pmem_resp         - physical data and single-cycle completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem1_read,
  input  lc3b_word      mem1_address,
  output lc3b_word      mem1_rdata,
  output logic          mem1_resp,
  input  logic          mem2_read,
  input  logic          mem2_write,
  input  lc3b_mem_wmask mem2_wmask,
  input  lc3b_word      mem2_address,
  input  lc3b_word      mem2_wdata,
  output lc3b_word      mem2_rdata,
  output logic          mem2_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  localparam int unsigned CNT_W = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  lc3b_arb_state    state_r;
  lc3b_arb_state    next_state_s;
  logic [CNT_W-1:0] starve_cnt_r;

  logic fetch_pend_s;
  logic data_pend_s;
  logic starve_hit_s;
  logic grant_i_s;
  logic grant_d_s;
  logic busy_s;
  logic next_read_s;
  logic next_write_s;

  logic          req_port_d_s;
  logic          req_write_s;
  lc3b_word      req_address_s;
  lc3b_word      req_wdata_s;
  lc3b_mem_wmask req_wmask_s;
  lc3b_word      load_wdata_s;
  lc3b_mem_wmask load_wmask_s;
  lc3b_word      load_address_s;

  logic     pmem_read_r;
  logic     pmem_write_r;
  logic     mem1_resp_r;
  logic     mem2_resp_r;
  lc3b_word mem1_rdata_r;
  lc3b_word mem2_rdata_r;

  // Arbitration: only evaluated in idle; both-pending goes to data unless
  // the starvation bound has been reached.
  always_comb begin
    fetch_pend_s = mem1_read;
    data_pend_s  = mem2_read | mem2_write;
    starve_hit_s = 1'b0;
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    if (STARVE_LIMIT != 32'd0) begin
      starve_hit_s = (starve_cnt_r == LIMIT_C);
    end else begin
      starve_hit_s = 1'b0;
    end
    if (state_r == arb_idle) begin
      if (fetch_pend_s && data_pend_s) begin
        if (starve_hit_s) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else if (fetch_pend_s) begin
        grant_i_s = 1'b1;
      end else if (data_pend_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Payload presented to the request latch; read+write together is a write.
  always_comb begin
    load_address_s = mem1_address;
    load_wdata_s   = WORD_ZERO;
    load_wmask_s   = WMASK_NONE;
    if (grant_d_s) begin
      load_address_s = mem2_address;
      load_wdata_s   = mem2_wdata;
      load_wmask_s   = mem2_wmask;
    end else begin
      load_address_s = mem1_address;
      load_wdata_s   = WORD_ZERO;
      load_wmask_s   = WMASK_NONE;
    end
  end

  // Next state and next physical strobes (strobes are registered from these).
  always_comb begin
    next_state_s = state_r;
    next_read_s  = 1'b0;
    next_write_s = 1'b0;
    case (state_r)
      arb_idle: begin
        if (grant_i_s) begin
          next_state_s = arb_i_busy;
          next_read_s  = 1'b1;
        end else if (grant_d_s) begin
          next_state_s = arb_d_busy;
          next_read_s  = ~mem2_write;
          next_write_s = mem2_write;
        end else begin
          next_state_s = arb_idle;
        end
      end
      arb_i_busy, arb_d_busy: begin
        if (pmem_resp) begin
          next_state_s = arb_done;
        end else begin
          next_state_s = state_r;
          next_read_s  = ~req_write_s;
          next_write_s = req_write_s;
        end
      end
      arb_done: begin
        next_state_s = arb_idle;
      end
      default: begin
        next_state_s = arb_idle;
      end
    endcase
  end

  assign busy_s = (state_r == arb_i_busy) || (state_r == arb_d_busy);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= arb_idle;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Starvation counter: cleared on a fetch grant, saturating count of data
  // grants taken while fetch was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= CNT_ZERO;
    end else if (grant_i_s) begin
      starve_cnt_r <= CNT_ZERO;
    end else if (grant_d_s && mem1_read && (starve_cnt_r != LIMIT_C)) begin
      starve_cnt_r <= starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered strobes, response pulses and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
      mem1_resp_r  <= 1'b0;
      mem2_resp_r  <= 1'b0;
      mem1_rdata_r <= WORD_ZERO;
      mem2_rdata_r <= WORD_ZERO;
    end else begin
      pmem_read_r  <= next_read_s;
      pmem_write_r <= next_write_s;
      mem1_resp_r  <= busy_s && pmem_resp && !req_port_d_s;
      mem2_resp_r  <= busy_s && pmem_resp && req_port_d_s;
      if (busy_s && pmem_resp && !req_port_d_s) begin
        mem1_rdata_r <= pmem_rdata;
      end else begin
        mem1_rdata_r <= mem1_rdata_r;
      end
      if (busy_s && pmem_resp && req_port_d_s) begin
        mem2_rdata_r <= pmem_rdata;
      end else begin
        mem2_rdata_r <= mem2_rdata_r;
      end
    end
  end

  arb_req_latch u_req_latch (
    .clk          (clk),
    .reset        (reset),
    .load         (grant_i_s | grant_d_s),
    .load_port_d  (grant_d_s),
    .load_write   (grant_d_s & mem2_write),
    .load_address (load_address_s),
    .load_wdata   (load_wdata_s),
    .load_wmask   (load_wmask_s),
    .port_d       (req_port_d_s),
    .write        (req_write_s),
    .address      (req_address_s),
    .wdata        (req_wdata_s),
    .wmask        (req_wmask_s)
  );

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = req_address_s;
  assign pmem_wdata   = req_wdata_s;
  assign pmem_wmask   = req_wmask_s;
  assign mem1_resp    = mem1_resp_r;
  assign mem2_resp    = mem2_resp_r;
  assign mem1_rdata   = mem1_rdata_r;
  assign mem2_rdata   = mem2_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (STARVE_LIMIT=2).
// Stimulus pushes the expected physical request and port response into
// queues; a monitor pops and compares whenever the DUT raises a strobe or a
// response. A behavioural physical memory answers after pm_lat cycles.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem1_read;
  lc3b_word      mem1_address;
  lc3b_word      mem1_rdata;
  logic          mem1_resp;
  logic          mem2_read;
  logic          mem2_write;
  lc3b_mem_wmask mem2_wmask;
  lc3b_word      mem2_address;
  lc3b_word      mem2_wdata;
  lc3b_word      mem2_rdata;
  logic          mem2_resp;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_mem_wmask pmem_wmask;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_word      pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem1_read    (mem1_read),
    .mem1_address (mem1_address),
    .mem1_rdata   (mem1_rdata),
    .mem1_resp    (mem1_resp),
    .mem2_read    (mem2_read),
    .mem2_write   (mem2_write),
    .mem2_wmask   (mem2_wmask),
    .mem2_address (mem2_address),
    .mem2_wdata   (mem2_wdata),
    .mem2_rdata   (mem2_rdata),
    .mem2_resp    (mem2_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wmask   (pmem_wmask),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct packed {
    logic       write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        port_d;
    logic [15:0] rdata;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pm_lat   = 2;
  bit   pm_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
    req_t r;
    r.write = w; r.addr = a; r.wdata = d; r.wmask = m;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic p, input logic [15:0] d);
    rsp_t r;
    r.port_d = p; r.rdata = d;
    exp_rsp_q.push_back(r);
  endtask

  // Physical memory contents as seen by the bench.
  function automatic logic [15:0] pm_data(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1234;
    else return a ^ 16'h5A5A;
  endfunction

  // Physical memory model: resp pm_lat cycles after the strobe is first seen.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = 16'hDEAD;
      if ((pmem_read || pmem_write) && !pm_stall && !reset) begin
        if (wait_cnt == pm_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pm_data(pmem_address);
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares strobes/payload against the queued request and
  // response pulses against the queued response.
  initial begin
    req_t cur;
    rsp_t r;
    bit   prev_act;
    bit   act;
    cur      = '0;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      act = pmem_read | pmem_write;
      check("strobe_exclusive", 32'(pmem_read & pmem_write), 32'd0);
      check("resp_exclusive", 32'(mem1_resp & mem2_resp), 32'd0);
      if (act && !prev_act) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_request_addr", 32'(pmem_address), 32'hFFFF_FFFF);
        end else begin
          cur = exp_req_q.pop_front();
          if (cur.write) begin
            check("pmem_wdata", 32'(pmem_wdata), 32'(cur.wdata));
            check("pmem_wmask", 32'(pmem_wmask), 32'(cur.wmask));
          end
        end
      end
      if (act) begin
        check("pmem_write", 32'(pmem_write), 32'(cur.write));
        check("pmem_read", 32'(pmem_read), 32'(!cur.write));
        check("pmem_address", 32'(pmem_address), 32'(cur.addr));
      end
      if (mem1_resp || mem2_resp) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_resp_mem2", 32'(mem2_resp), 32'hFFFF_FFFF);
        end else begin
          r = exp_rsp_q.pop_front();
          check("resp_port_d", 32'(mem2_resp), 32'(r.port_d));
          check("resp_rdata", mem2_resp ? 32'(mem2_rdata) : 32'(mem1_rdata), 32'(r.rdata));
        end
      end
      prev_act = act;
    end
  end

  // Wait (bounded) for: 1 mem1_resp, 2 mem2_resp, 3 any pmem strobe.
  task automatic wait_sig(input int which, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ((which == 1 && mem1_resp) || (which == 2 && mem2_resp) ||
          (which == 3 && (pmem_read || pmem_write))) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic fetch(input logic [15:0] a);
    mem1_address = a;
    mem1_read    = 1'b1;
    wait_sig(1, "mem1_resp_seen");
    mem1_read    = 1'b0;
  endtask

  task automatic data_op(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] m);
    mem2_read    = rd;
    mem2_write   = wr;
    mem2_address = a;
    mem2_wdata   = d;
    mem2_wmask   = m;
    wait_sig(2, "mem2_resp_seen");
    mem2_read    = 1'b0;
    mem2_write   = 1'b0;
  endtask

  // Let outstanding expectations drain, then require both queues empty.
  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_req_q.size() == 0 && exp_rsp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_req_left"}, 32'(exp_req_q.size()), 32'd0);
    check({name, "_rsp_left"}, 32'(exp_rsp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem1_read = 1'b0; mem1_address = 16'h0000;
    mem2_read = 1'b0; mem2_write = 1'b0; mem2_wmask = 2'b00;
    mem2_address = 16'h0000; mem2_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_pmem_write", 32'(pmem_write), 32'd0);
    check("rst_pmem_address", 32'(pmem_address), 32'd0);
    check("rst_pmem_wdata", 32'(pmem_wdata), 32'd0);
    check("rst_pmem_wmask", 32'(pmem_wmask), 32'd0);
    check("rst_mem1_resp", 32'(mem1_resp), 32'd0);
    check("rst_mem2_resp", 32'(mem2_resp), 32'd0);
    check("rst_mem1_rdata", 32'(mem1_rdata), 32'd0);
    check("rst_mem2_rdata", 32'(mem2_rdata), 32'd0);
    check("rst_state", 32'(dut.state_r), 32'(arb_idle));
    reset = 1'b0;
    @(posedge clk); #1;

    // Fetch only.
    pm_lat = 2;
    push_req(1'b0, 16'h3000, 16'h0000, 2'b00);
    push_rsp(1'b0, 16'h1234);
    fetch(16'h3000);
    drain("fetch_only");

    // Simultaneous: data write wins, then fetch.
    push_req(1'b1, 16'h0020, 16'h00AB, 2'b01);
    push_rsp(1'b1, 16'h5A7A);
    push_req(1'b0, 16'h0010, 16'h0000, 2'b00);
    push_rsp(1'b0, 16'h5A4A);
    fork
      fetch(16'h0010);
      data_op(1'b0, 1'b1, 16'h0020, 16'h00AB, 2'b01);
    join
    drain("simultaneous");
    check("starve_cnt_after_simul", 32'(dut.starve_cnt_r), 32'd0);

    // Starvation bound of 2: D, D, I, then the last D.
    pm_lat = 1;
    push_req(1'b0, 16'h0100, 16'h0000, 2'b00); push_rsp(1'b1, 16'h5B5A);
    push_req(1'b0, 16'h0102, 16'h0000, 2'b00); push_rsp(1'b1, 16'h5B58);
    push_req(1'b0, 16'h0200, 16'h0000, 2'b00); push_rsp(1'b0, 16'h585A);
    push_req(1'b0, 16'h0104, 16'h0000, 2'b00); push_rsp(1'b1, 16'h5B5E);
    fork
      fetch(16'h0200);
      begin
        data_op(1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
        data_op(1'b1, 1'b0, 16'h0102, 16'h0000, 2'b00);
        data_op(1'b1, 1'b0, 16'h0104, 16'h0000, 2'b00);
      end
    join
    drain("starvation");
    check("starve_cnt_after_starve", 32'(dut.starve_cnt_r), 32'd0);

    // Requester drops mem2_read one cycle after grant.
    pm_lat = 3;
    push_req(1'b0, 16'h0040, 16'h0000, 2'b00);
    push_rsp(1'b1, 16'h5A1A);
    mem2_address = 16'h0040;
    mem2_read    = 1'b1;
    wait_sig(3, "drop_grant_seen");
    @(posedge clk); #1;
    mem2_read    = 1'b0;
    mem2_address = 16'hFFFF;
    check("drop_read_held", 32'(pmem_read), 32'd1);
    wait_sig(2, "drop_mem2_resp_seen");
    drain("drop");

    // Read and write together: treated as a write.
    pm_lat = 0;
    push_req(1'b1, 16'h0300, 16'hBEEF, 2'b11);
    push_rsp(1'b1, 16'h595A);
    data_op(1'b1, 1'b1, 16'h0300, 16'hBEEF, 2'b11);
    drain("read_write");

    // Reset during D_BUSY: no response, then a normal fetch.
    pm_stall = 1'b1;
    push_req(1'b0, 16'h0400, 16'h0000, 2'b00);
    mem2_address = 16'h0400;
    mem2_read    = 1'b1;
    wait_sig(3, "rst_grant_seen");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_pmem_read", 32'(pmem_read), 32'd0);
    check("midrst_pmem_write", 32'(pmem_write), 32'd0);
    check("midrst_mem2_resp", 32'(mem2_resp), 32'd0);
    check("midrst_mem2_rdata", 32'(mem2_rdata), 32'd0);
    check("midrst_state", 32'(dut.state_r), 32'(arb_idle));
    reset     = 1'b0;
    mem2_read = 1'b0;
    pm_stall  = 1'b0;
    pm_lat    = 2;
    repeat (5) @(posedge clk);
    #1;
    push_req(1'b0, 16'h3000, 16'h0000, 2'b00);
    push_rsp(1'b0, 16'h1234);
    fetch(16'h3000);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
